// File: rtl/stack_rpn_sequencer.sv
// RPN token sequencer: turns operand/operator/end tokens into opcodes for an external
// arithmetic stack, tracks stack depth, and reports one result (or error) per expression.
module stack_rpn_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_kind,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_code,
    output logic [2:0]       stk_opcode,
    output logic [WIDTH-1:0] stk_input_data,
    input  logic [WIDTH-1:0] stk_output_data,
    input  logic             stk_overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthVal = CW'(DEPTH);
    localparam logic [CW-1:0] One      = CW'(1);
    localparam logic [CW-1:0] Two      = CW'(2);

    localparam logic [1:0] KindOperand = 2'b00;
    localparam logic [1:0] KindAdd     = 2'b01;
    localparam logic [1:0] KindMul     = 2'b10;
    localparam logic [1:0] KindEnd     = 2'b11;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpPush = 3'b110;
    localparam logic [2:0] OpPop  = 3'b111;

    typedef enum logic [2:0] {
        StIdle, StExec, StSettle, StDiscard, StFlush, StFlushWait, StCapture, StResult
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       kind_q, kind_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic accept;
    assign accept = tok_valid && tok_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            kind_q     <= KindOperand;
            data_q     <= '0;
            err_q      <= 2'b00;
            ovf_q      <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            kind_q     <= kind_d;
            data_q     <= data_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        kind_d     = kind_q;
        data_d     = data_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        res_data_d = res_data_q;
        tok_ready  = 1'b0;
        res_valid  = 1'b0;
        stk_opcode = OpNop;

        case (state_q)
            StIdle: begin
                // Gated by rst_n so nothing is offered while reset is held.
                tok_ready = rst_n;
                if (accept) begin
                    unique case (tok_kind)
                        KindOperand: begin
                            if (count_q == DepthVal) begin
                                err_d   = (err_q != 2'b00) ? err_q : 2'b10;
                                state_d = StDiscard;
                            end else begin
                                kind_d  = tok_kind;
                                data_d  = tok_data;
                                state_d = StExec;
                            end
                        end
                        KindAdd, KindMul: begin
                            if (count_q < Two) begin
                                err_d   = (err_q != 2'b00) ? err_q : 2'b01;
                                state_d = StDiscard;
                            end else begin
                                kind_d  = tok_kind;
                                state_d = StExec;
                            end
                        end
                        KindEnd: begin
                            if (count_q != One) begin
                                err_d   = (err_q != 2'b00) ? err_q : 2'b01;
                                state_d = (count_q == '0) ? StResult : StFlush;
                            end else begin
                                kind_d  = tok_kind;
                                state_d = StExec;
                            end
                        end
                    endcase
                end
            end
            StExec: begin
                unique case (kind_q)
                    KindOperand: begin
                        stk_opcode = OpPush;
                        count_d    = count_q + One;
                    end
                    KindAdd: begin
                        stk_opcode = OpAdd;
                        count_d    = count_q - One;
                    end
                    KindMul: begin
                        stk_opcode = OpMul;
                        count_d    = count_q - One;
                    end
                    KindEnd: begin
                        stk_opcode = OpPop;
                        count_d    = '0;
                    end
                endcase
                state_d = StSettle;
            end
            StSettle: begin
                if ((kind_q == KindAdd || kind_q == KindMul) && stk_overflow) begin
                    ovf_d = 1'b1;
                end
                state_d = (kind_q == KindEnd) ? StCapture : StIdle;
            end
            StDiscard: begin
                tok_ready = 1'b1;
                if (accept && tok_kind == KindEnd) begin
                    state_d = (count_q == '0) ? StResult : StFlush;
                end
            end
            StFlush: begin
                stk_opcode = OpPop;
                count_d    = count_q - One;
                state_d    = StFlushWait;
            end
            StFlushWait: begin
                state_d = (count_q == '0) ? StResult : StFlush;
            end
            StCapture: begin
                res_data_d = stk_output_data;
                state_d    = StResult;
            end
            StResult: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    // Clearing res_data here makes the error/flush path report zero.
                    err_d      = 2'b00;
                    ovf_d      = 1'b0;
                    res_data_d = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_data       = res_data_q;
    assign res_code       = (err_q != 2'b00) ? err_q : (ovf_q ? 2'b11 : 2'b00);
    assign stk_input_data = data_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench for stack_rpn_sequencer: behavioural stack environment, expression-level RPN model,
// per-cycle compare process, directed scenarios and randomized expressions.
module tb_stack_rpn_sequencer;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 8;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));
    localparam logic [1:0] KOpd = 2'b00;
    localparam logic [1:0] KAdd = 2'b01;
    localparam logic [1:0] KMul = 2'b10;
    localparam logic [1:0] KEnd = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tok_valid = 1'b0;
    logic         tok_ready;
    logic [1:0]   tok_kind = 2'b00;
    logic [W-1:0] tok_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic [1:0]   res_code;
    logic [2:0]   stk_opcode;
    logic [W-1:0] stk_input_data;
    logic [W-1:0] stk_output_data;
    logic         stk_overflow;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stack_rpn_sequencer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tok_valid       (tok_valid),
        .tok_ready       (tok_ready),
        .tok_kind        (tok_kind),
        .tok_data        (tok_data),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_code        (res_code),
        .stk_opcode      (stk_opcode),
        .stk_input_data  (stk_input_data),
        .stk_output_data (stk_output_data),
        .stk_overflow    (stk_overflow),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed arithmetic with wrap; bit W flags a result outside the signed range.
    function automatic logic [W:0] arith(input logic [1:0] k, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = (k == KAdd) ? sa + sb : sa * sb;
        return {(r > MAXV || r < MINV), r[W-1:0]};
    endfunction

    // Attached stack environment, sharing the DUT reset.
    logic [W-1:0] mem [DEPTH];
    int env_sp, env_viol, push_cnt, pop_cnt;
    initial begin
        env_viol = 0;
        push_cnt = 0;
        pop_cnt  = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_sp          <= 0;
            stk_output_data <= '0;
            stk_overflow    <= 1'b0;
        end else begin
            case (stk_opcode)
                3'b110: begin
                    if (env_sp >= int'(DEPTH)) env_viol <= env_viol + 1;
                    else begin
                        mem[env_sp] <= stk_input_data;
                        env_sp      <= env_sp + 1;
                    end
                    push_cnt     <= push_cnt + 1;
                    stk_overflow <= 1'b0;
                end
                3'b100, 3'b101: begin
                    if (env_sp < 2) env_viol <= env_viol + 1;
                    else begin
                        logic [W:0] ar;
                        ar = arith((stk_opcode == 3'b100) ? KAdd : KMul,
                                   mem[env_sp-2], mem[env_sp-1]);
                        mem[env_sp-2]   <= ar[W-1:0];
                        stk_output_data <= ar[W-1:0];
                        stk_overflow    <= ar[W];
                        env_sp          <= env_sp - 1;
                    end
                end
                3'b111: begin
                    if (env_sp < 1) env_viol <= env_viol + 1;
                    else begin
                        stk_output_data <= mem[env_sp-1];
                        env_sp          <= env_sp - 1;
                    end
                    pop_cnt      <= pop_cnt + 1;
                    stk_overflow <= 1'b0;
                end
                3'b000: ;
                default: env_viol <= env_viol + 1;
            endcase
        end
    end

    // Expression under test and its expected outcome.
    logic [1:0]   tk_kind[$];
    logic [W-1:0] tk_data[$];
    logic [1:0]   exp_code;
    logic [W-1:0] exp_data;
    int           exp_pushes, exp_pops;
    bit           exp_valid = 1'b0;
    logic [W-1:0] last_sent = '0;

    task automatic model_eval();
        logic [W-1:0] q[$];
        logic [W-1:0] a, b;
        logic [W:0]   ar;
        logic [1:0]   err;
        bit           ovf, disc, done;
        err = 2'b00; ovf = 0; disc = 0; done = 0;
        exp_pushes = 0; exp_pops = 0; exp_data = '0;
        for (int i = 0; i < tk_kind.size() && !done; i++) begin
            if (disc) begin
                if (tk_kind[i] == KEnd) begin
                    exp_pops = q.size();
                    done = 1;
                end
            end else if (tk_kind[i] == KOpd) begin
                if (q.size() == DEPTH) begin err = 2'b10; disc = 1; end
                else begin q.push_back(tk_data[i]); exp_pushes++; end
            end else if (tk_kind[i] == KEnd) begin
                if (q.size() != 1) begin err = 2'b01; exp_pops = q.size(); end
                else begin exp_data = q[0]; exp_pops = 1; end
                done = 1;
            end else begin
                if (q.size() < 2) begin err = 2'b01; disc = 1; end
                else begin
                    b = q.pop_back();
                    a = q.pop_back();
                    ar = arith(tk_kind[i], a, b);
                    ovf = ovf | ar[W];
                    q.push_back(ar[W-1:0]);
                end
            end
        end
        exp_code = (err != 2'b00) ? err : (ovf ? 2'b11 : 2'b00);
    endtask

    // Compare process: every falling edge.
    initial begin
        bit rv_prev;
        rv_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs",
                    {tok_ready, res_valid, res_data, res_code, stk_opcode, stk_input_data, busy},
                    64'd0);
                rv_prev = 0;
            end else begin
                chk("stack_depth_range", (env_sp >= 0 && env_sp <= int'(DEPTH)), 1);
                if (stk_opcode == 3'b110) chk("push_data", stk_input_data, last_sent);
                if (res_valid) begin
                    chk("res_expected", exp_valid, 1);
                    chk("res_data", res_data, exp_data);
                    chk("res_code", res_code, exp_code);
                    chk("result_quiet", {stk_opcode, tok_ready, busy}, {3'b000, 1'b0, 1'b1});
                    chk("stack_empty_at_result", env_sp, 0);
                    if (!rv_prev) begin
                        chk("push_count", push_cnt, exp_pushes);
                        chk("pop_count", pop_cnt, exp_pops);
                    end
                end
                rv_prev = res_valid;
            end
        end
    end

    task automatic add_tok(input logic [1:0] k, input logic [W-1:0] d);
        tk_kind.push_back(k);
        tk_data.push_back(d);
    endtask

    task automatic send_tok(input logic [1:0] k, input logic [W-1:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_kind  = k;
        tok_data  = d;
        if (k == KOpd) last_sent = d;
        n = 0;
        while (!tok_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) chk("tok_ready_timeout", 0, 1);
        @(posedge clk);
        #1 tok_valid = 1'b0;
        tok_data = W'($urandom);
    endtask

    task automatic wait_result(input int hold);
        int n;
        n = 0;
        while (!res_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            chk("result_timeout", 0, 1);
            return;
        end
        // Offer a token while the result is held; it must not be taken.
        tok_valid = (hold > 0);
        tok_kind  = KOpd;
        repeat (hold) @(negedge clk);
        tok_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("res_released", {res_valid, busy, tok_ready}, 3'b001);
    endtask

    task automatic run_expr(input int hold, input bit gaps);
        model_eval();
        push_cnt  = 0;
        pop_cnt   = 0;
        exp_valid = 1'b1;
        for (int i = 0; i < tk_kind.size(); i++) begin
            send_tok(tk_kind[i], (tk_kind[i] == KOpd) ? tk_data[i] : W'($urandom),
                     gaps ? int'($urandom_range(0, 2)) : 0);
            if (tk_kind[i] == KEnd) break;
        end
        wait_result(hold);
        exp_valid = 1'b0;
        tk_kind.delete();
        tk_data.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {tok_ready, busy}, 2'b10);

        // 3 4 + 5 * -> 35
        add_tok(KOpd, 3); add_tok(KOpd, 4); add_tok(KAdd, 0);
        add_tok(KOpd, 5); add_tok(KMul, 0); add_tok(KEnd, 0);
        model_eval();
        chk("model_35", {exp_code, exp_data}, {2'b00, 16'd35});
        run_expr(0, 0);

        // Signed overflow still reports the popped value
        add_tok(KOpd, 16'h7FFF); add_tok(KOpd, 16'h0001); add_tok(KAdd, 0); add_tok(KEnd, 0);
        model_eval();
        chk("model_ovf", {exp_code, exp_data}, {2'b11, 16'h8000});
        run_expr(0, 0);

        // Operator on empty stack: 7 discarded, nothing pushed
        add_tok(KAdd, 0); add_tok(KOpd, 7); add_tok(KEnd, 0);
        model_eval();
        chk("model_underflow", {exp_code, exp_data, 8'(exp_pushes)}, {2'b01, 16'd0, 8'd0});
        run_expr(0, 0);

        // DEPTH+1 operands: full error, DEPTH pops in flush
        for (int i = 0; i <= int'(DEPTH); i++) add_tok(KOpd, W'(i + 1));
        add_tok(KEnd, 0);
        model_eval();
        chk("model_full", {exp_code, 8'(exp_pops)}, {2'b10, 8'(DEPTH)});
        run_expr(0, 0);

        // End with two values left: malformed, both flushed
        add_tok(KOpd, 1); add_tok(KOpd, 2); add_tok(KEnd, 0);
        run_expr(0, 0);

        // Reset during the EXEC of a push
        send_tok(KOpd, 16'd9, 0);
        @(negedge clk);
        chk("exec_push_seen", stk_opcode, 3'b110);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", {tok_ready, busy}, 2'b10);
        add_tok(KOpd, 2); add_tok(KOpd, 3); add_tok(KMul, 0); add_tok(KEnd, 0);
        model_eval();
        chk("model_6", {exp_code, exp_data}, {2'b00, 16'd6});
        run_expr(0, 0);

        // Result held 10 cycles
        add_tok(KOpd, 16'd12); add_tok(KOpd, 16'hFFFF); add_tok(KMul, 0); add_tok(KEnd, 0);
        run_expr(10, 0);

        // Randomized expressions, occasionally malformed
        for (int e = 0; e < 40; e++) begin
            int  c, len;
            bit  ended;
            c = 0; ended = 0;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len && !ended; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    logic [1:0] k;
                    k = 2'($urandom_range(0, 3));
                    add_tok(k, W'($urandom));
                    if (k == KEnd) ended = 1;
                end else if (c >= 2 && $urandom_range(0, 1) == 1) begin
                    add_tok($urandom_range(0, 1) ? KAdd : KMul, 0);
                    c--;
                end else begin
                    add_tok(KOpd, $urandom_range(0, 1) ? W'($urandom_range(0, 20)) : W'($urandom));
                    c++;
                end
            end
            if (!ended) begin
                if ($urandom_range(0, 3) != 0) begin
                    while (c > 1) begin
                        add_tok($urandom_range(0, 1) ? KAdd : KMul, 0);
                        c--;
                    end
                end
                add_tok(KEnd, 0);
            end
            run_expr(int'($urandom_range(0, 3)), 1);
        end

        chk("stack_env_violations", env_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stack_rpn_sequencer.md
STACK_RPN_SEQUENCER -- requirements
Module: stack_rpn_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits.
REQ-002 Parameter DEPTH, default 256: capacity of the attached stack; sequencer depth counter range is 0..DEPTH.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset; shared with the attached stack.
REQ-005 tok_valid  in  1  token offered.
REQ-006 tok_ready  out  1  token accepted when tok_valid && tok_ready at a rising edge.
REQ-007 tok_kind  in  2  00 operand, 01 add, 10 mul, 11 end.
REQ-008 tok_data  in  WIDTH  operand value; ignored for other kinds.
REQ-009 res_valid  out  1  result offered; held until res_ready.
REQ-010 res_ready  in  1  result consumed when res_valid && res_ready.
REQ-011 res_data  out  WIDTH  expression result.
REQ-012 res_code  out  2  00 ok, 01 underflow/malformed, 10 stack full, 11 arithmetic overflow.
REQ-013 stk_opcode  out  3  to stack: 000 nop, 100 add, 101 mul, 110 push, 111 pop.
REQ-014 stk_input_data  out  WIDTH  push data to stack.
REQ-015 stk_output_data  in  WIDTH  stack top/result output.
REQ-016 stk_overflow  in  1  stack arithmetic overflow flag.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, SETTLE, DISCARD, FLUSH, FLUSH_WAIT, CAPTURE, RESULT.
REQ-019 tok_ready SHALL be 1 only in IDLE and DISCARD; stk_opcode SHALL be 000 in every state except EXEC and FLUSH.
REQ-020 Operand accepted in IDLE with count<DEPTH: EXEC drives 110 with stk_input_data=tok_data for exactly one cycle; count+1; SETTLE one cycle; back to IDLE (one token per 3 cycles max).
REQ-021 add/mul accepted in IDLE with count>=2: EXEC drives 100/101 for one cycle; count-1; in SETTLE, stk_overflow=1 SHALL latch sticky ovf flag.
REQ-022 end accepted in IDLE with count==1: EXEC drives 111; count=0; SETTLE; CAPTURE registers res_data=stk_output_data; RESULT.
REQ-023 Errors, first one latched wins: operand with count==DEPTH -> code 10; operator with count<2, or end with count!=1 -> code 01; no stack opcode issued for the erroring token.
REQ-024 After an error on a non-end token: DISCARD consumes and drops tokens until an end token is accepted, then FLUSH.
REQ-025 FLUSH: drive 111 one cycle, count-1, FLUSH_WAIT one cycle; repeat until count==0; then RESULT with res_data=0.
REQ-026 RESULT: res_valid=1, res_data/res_code stable until res_ready; on handshake -> IDLE, ovf flag and error latch cleared.
REQ-027 res_code priority: latched error code, else 11 if ovf flag set, else 00; with code 11 res_data SHALL still be the popped value.
REQ-028 Width: tok_data passed unmodified to stk_input_data; no arithmetic performed in sequencer.
REQ-029 count SHALL never exceed DEPTH nor go below 0 under any token sequence.

Reset
REQ-030 While rst_n=0: state IDLE, count=0, tok_ready=0, res_valid=0, res_data=0, res_code=00, stk_opcode=000, stk_input_data=0, busy=0, flags cleared.
REQ-031 Reset asserted in any state SHALL abort the operation immediately; tok_ready=1 from first cycle after deassertion.

Verification
REQ-032 Tokens 3, 4, add, 5, mul, end -> res_valid, res_data=35, res_code=00, stack empty afterwards.
REQ-033 Tokens 0x7FFF, 0x0001, add, end -> res_code=11, res_data=stack output at pop.
REQ-034 Tokens add, 7, end on empty stack -> code 01, token 7 discarded (no 110 issued), res_data=0.
REQ-035 DEPTH+1 operands then end -> code 10, exactly DEPTH pops in FLUSH, count=0 at res_valid.
REQ-036 rst_n pulsed low during EXEC of a push -> all outputs at reset values; then 2, 3, mul, end -> res_data=6, code 00.
REQ-037 res_ready held low 10 cycles in RESULT -> res_valid, res_data, res_code stable, tok_ready=0, stk_opcode=000.
